dis_scan: RTL
=============

# dis_scan

Downstream read-out stage for the replica array's total-distance chain. On command it rotates the chain once (replica_num shifts), recirculating every value so the chain is left unchanged, and tracks the minimum total distance and its replica index. It can optionally stream each value to the host over a valid/ready port. It sits between the replica array's distance_shift / distance_wdata / distance_rdata ports and the host register block.

## Interface
Parameters:
- replica_num, 32, number of replicas in the chain (≥2)
- idx_w, $clog2(replica_num), replica index width

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle scan request
- opt_busy  input  1  optimisation running; scan must not shift while high
- stream_en  input  1  sampled at start; 1 = present each value on rd_* port
- busy  output  1  scan in progress (any state but IDLE)
- done  output  1  one-cycle pulse at scan completion
- min_dis  output  total_data_t  smallest total distance of last scan
- min_idx  output  idx_w  replica index holding min_dis
- rd_valid  output  1  streamed value valid
- rd_ready  input  1  host accepts streamed value
- rd_data  output  total_data_t  streamed distance
- rd_idx  output  idx_w  replica index of rd_data
- distance_shift  output  1  shift enable to replica chain
- distance_wdata  output  total_data_t  value inserted at chain head
- distance_rdata  input  total_data_t  chain tail (replica replica_num-1)

## Operation
- States: IDLE, WAIT, SHIFT, DONE.
- IDLE: start=1 → latch stream_en into stream_q, clear cnt, go to WAIT if opt_busy else SHIFT. start in any other state is ignored.
- WAIT: stay while opt_busy; go to SHIFT the first cycle opt_busy=0.
- SHIFT: fire = !opt_busy && (!stream_q || rd_ready). When fire, distance_shift=1, distance_wdata=distance_rdata (recirculate), cnt+1. If opt_busy rises mid-scan, fire is held 0 (no shift, no state change).
- Captured value k (k=0..replica_num-1) belongs to replica replica_num-1-k.
- Minimum: at k=0 load unconditionally; afterwards update when value ≤ running min (unsigned). Ties therefore resolve to the lowest replica index.
- Running min/idx are internal. min_dis/min_idx are copied to the outputs on the DONE cycle and hold until the next DONE.
- The fire with cnt=replica_num-1 goes to DONE. DONE: done=1 for one cycle, then IDLE.
- Stream: in SHIFT with stream_q=1 and !opt_busy: rd_valid=1, rd_data=distance_rdata, rd_idx=replica_num-1-cnt. A transfer is rd_valid&&rd_ready, coinciding with the fire. rd_valid is 0 in every other state and whenever stream_q=0.
- distance_wdata=distance_rdata whenever distance_shift=1, and 0 otherwise.

## Timing
- Reset values: busy=0, done=0, min_dis=0, min_idx=0, rd_valid=0, rd_data=0, rd_idx=0, distance_shift=0, distance_wdata=0. State=IDLE, cnt=0.
- With stream_en=0 and opt_busy=0: start at cycle t → distance_shift high t+1..t+replica_num → done at t+replica_num+1 → busy low at t+replica_num+2.
- distance_shift, distance_wdata and rd_* are combinational from state/cnt/distance_rdata/rd_ready/opt_busy. No register sits between distance_rdata and distance_wdata, so recirculation is zero-latency.
- rd_ready low stalls indefinitely with no timeout. rd_valid stays asserted and rd_data stays stable while rd_ready is low and opt_busy is low.
- Reset mid-scan: return to IDLE immediately. The chain may be left partially rotated; software reloads it.
- start and the DONE cycle coincide: start is ignored.

## Configuration
- DIS_SCAN_SUM_EN defined: adds output sum_dis, width total_data_t bits + idx_w + 1, reset 0.
  - Accumulates the captured values (zero-extended, no overflow possible).
  - The accumulator clears at start and is copied to sum_dis on DONE.
- DIS_SCAN_SUM_EN undefined: no sum_dis port and no accumulator logic.

## Test plan
- replica_num=4, chain tail order 70,30,50,30, stream_en=0, opt_busy=0: start → exactly 4 distance_shift cycles, done 5 cycles after start; min_dis=30, min_idx=0; chain contents unchanged (second scan gives identical results).
- Same chain, stream_en=1, rd_ready toggled 1,0,0,1,1,0,1: 4 transfers with (rd_idx,rd_data) = (3,70),(2,30),(1,50),(0,30); no shift while rd_ready=0; done after the 4th transfer.
- opt_busy=1 at start for 5 cycles: stays in WAIT with busy=1 and no shifts; scan then completes normally. opt_busy pulsed high after 2 shifts: shifts pause and resume, and the final min is correct.
- start pulsed during SHIFT and on the DONE cycle: ignored, so no extra shifts and a single done pulse.
- reset asserted after 2 shifts: all outputs return to 0 asynchronously. A new start after reset gives 4 shifts.
- With DIS_SCAN_SUM_EN and values 70,30,50,30: sum_dis=180 at done. With all values at max total_data_t: sum_dis=4×max with no wrap.

Source files
------------

// File: rtl/dis_scan.sv
// Read-out scan of the replica total-distance chain: rotates the chain once,
// tracks the minimum and its replica index, optionally streams each value.
// Optional feature macro: DIS_SCAN_SUM_EN adds the sum_dis accumulator output.
module dis_scan #(
    parameter int replica_num = 32,
    parameter int dis_w       = 16,
    parameter int idx_w       = $clog2(replica_num)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             opt_busy,
    input  logic             stream_en,
    output logic             busy,
    output logic             done,
    output logic [dis_w-1:0] min_dis,
    output logic [idx_w-1:0] min_idx,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [dis_w-1:0] rd_data,
    output logic [idx_w-1:0] rd_idx,
    output logic             distance_shift,
    output logic [dis_w-1:0] distance_wdata,
    input  logic [dis_w-1:0] distance_rdata
`ifdef DIS_SCAN_SUM_EN
    ,
    output logic [dis_w+idx_w:0] sum_dis
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [idx_w-1:0] last_idx = idx_w'(replica_num - 1);

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [idx_w-1:0] cnt_reg;
    logic             stream_reg;
    logic [dis_w-1:0] run_min_reg;
    logic [idx_w-1:0] run_idx_reg;

    logic             fire;
    logic             last_fire;
    logic             take;
    logic [idx_w-1:0] cap_idx;
    logic [dis_w-1:0] new_min;
    logic [idx_w-1:0] new_idx;

    // The k-th captured value sits at replica replica_num-1-k; taking ties with
    // <= lets later captures (lower replica indices) win.
    assign cap_idx   = last_idx - cnt_reg;
    assign fire      = (state_reg == ST_SHIFT) && !opt_busy && (!stream_reg || rd_ready);
    assign last_fire = fire && (cnt_reg == last_idx);
    assign take      = (cnt_reg == '0) || (distance_rdata <= run_min_reg);
    assign new_min   = take ? distance_rdata : run_min_reg;
    assign new_idx   = take ? cap_idx : run_idx_reg;

    assign busy           = (state_reg != ST_IDLE);
    assign done           = (state_reg == ST_DONE);
    assign distance_shift = fire;
    assign distance_wdata = fire ? distance_rdata : '0;
    assign rd_valid       = (state_reg == ST_SHIFT) && stream_reg && !opt_busy;
    assign rd_data        = rd_valid ? distance_rdata : '0;
    assign rd_idx         = rd_valid ? cap_idx : '0;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = opt_busy ? ST_WAIT : ST_SHIFT;
            ST_WAIT:  if (!opt_busy) state_next = ST_SHIFT;
            ST_SHIFT: if (last_fire) state_next = ST_DONE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            stream_reg  <= 1'b0;
            run_min_reg <= '0;
            run_idx_reg <= '0;
            min_dis     <= '0;
            min_idx     <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && start) begin
                stream_reg <= stream_en;
                cnt_reg    <= '0;
            end
            if (fire) begin
                cnt_reg     <= cnt_reg + 1'b1;
                run_min_reg <= new_min;
                run_idx_reg <= new_idx;
            end
            // Published on the edge into DONE so the result is visible with done.
            if (last_fire) begin
                min_dis <= new_min;
                min_idx <= new_idx;
            end
        end
    end

`ifdef DIS_SCAN_SUM_EN
    logic [dis_w+idx_w:0] sum_reg;
    logic [dis_w+idx_w:0] sum_new;

    assign sum_new = sum_reg + (dis_w + idx_w + 1)'(distance_rdata);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_reg <= '0;
            sum_dis <= '0;
        end else begin
            if (state_reg == ST_IDLE && start) begin
                sum_reg <= '0;
            end else if (fire) begin
                sum_reg <= sum_new;
            end
            if (last_fire) begin
                sum_dis <= sum_new;
            end
        end
    end
`endif

endmodule
